// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the EX operand stage: ALU op codes, register widths,
// the held-entry bundle and the writeback-hit helper.
package ex_operand_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_RSUB = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_ANDN = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_XNOR = 3'b111
  } alu_op_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  typedef struct packed {
    word_t     a;
    word_t     b;
    logic [2:0] alu_op;
    reg_addr_t rd_addr;
    logic      reg_write;
  } ex_ops_t;

  // r0 is hardwired, so a write to it never produces a hit
  function automatic logic wb_hit(
    input logic      we,
    input reg_addr_t addr,
    input reg_addr_t src
  );
    return we && (addr == src) && (addr != '0);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-to-EX and EX-to-ALU valid/ready bundle for the operand stage.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic       in_valid;
  logic       in_ready;
  reg_addr_t  in_rs_addr;
  reg_addr_t  in_rt_addr;
  word_t      in_rs_data;
  word_t      in_rt_data;
  word_t      in_imm;
  logic       in_use_imm;
  logic [2:0] in_alu_op;
  reg_addr_t  in_rd_addr;
  logic       in_reg_write;

  logic       out_valid;
  logic       out_ready;
  word_t      out_a;
  word_t      out_b;
  logic [2:0] out_alu_op;
  reg_addr_t  out_rd_addr;
  logic       out_reg_write;

  modport master (
    output in_valid, in_rs_addr, in_rt_addr,
    output in_rs_data, in_rt_data, in_imm,
    output in_use_imm, in_alu_op,
    output in_rd_addr, in_reg_write,
    input  in_ready,
    input  out_valid, out_a, out_b,
    input  out_alu_op, out_rd_addr, out_reg_write,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs_addr, in_rt_addr,
    input  in_rs_data, in_rt_data, in_imm,
    input  in_use_imm, in_alu_op,
    input  in_rd_addr, in_reg_write,
    output in_ready,
    output out_valid, out_a, out_b,
    output out_alu_op, out_rd_addr, out_reg_write,
    input  out_ready
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// One-operand bypass mux: EX/MEM beats MEM/WB beats register file.
// Bypassing is present only when EX_OPERAND_FORWARD_EN is defined.
module fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  reg_addr_t src_addr,
  input  word_t     reg_data,
  input  logic      exm_we,
  input  reg_addr_t exm_addr,
  input  word_t     exm_data,
  input  logic      mwb_we,
  input  reg_addr_t mwb_addr,
  input  word_t     mwb_data,
  output word_t     data
);

`ifdef EX_OPERAND_FORWARD_EN
  always_comb begin
    data = reg_data;
    if (wb_hit(exm_we, exm_addr, src_addr)) begin
      data = exm_data;
    end else if (wb_hit(mwb_we, mwb_addr, src_addr)) begin
      data = mwb_data;
    end
  end
`else
  // hazards are interlocked upstream, so the file value is always current
  logic unused_fwd;
  assign unused_fwd = ^{src_addr, exm_we, exm_addr, exm_data,
                        mwb_we, mwb_addr, mwb_data};
  assign data = reg_data;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// Single-entry EX operand register with bypass or interlock.
// Define EX_OPERAND_FORWARD_EN to bypass instead of interlocking.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ex_operand_stage_if.slave  bus,
  input  logic               flush,
  input  logic               exm_we,
  input  reg_addr_t          exm_addr,
  input  word_t              exm_data,
  input  logic               mwb_we,
  input  reg_addr_t          mwb_addr,
  input  word_t              mwb_data,
  output logic [15:0]        stall_cnt
);

  word_t   fwd_a;
  word_t   fwd_b;
  ex_ops_t ops_q;
  ex_ops_t ops_d;
  logic    valid_q;
  logic    interlock;
  logic    accept;
  logic    stalled;

  fwd_mux u_fwd_a (
    .src_addr (bus.in_rs_addr),
    .reg_data (bus.in_rs_data),
    .exm_we   (exm_we),
    .exm_addr (exm_addr),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_addr (mwb_addr),
    .mwb_data (mwb_data),
    .data     (fwd_a)
  );

  fwd_mux u_fwd_b (
    .src_addr (bus.in_rt_addr),
    .reg_data (bus.in_rt_data),
    .exm_we   (exm_we),
    .exm_addr (exm_addr),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_addr (mwb_addr),
    .mwb_data (mwb_data),
    .data     (fwd_b)
  );

`ifdef EX_OPERAND_FORWARD_EN
  assign interlock = 1'b0;
`else
  logic rs_busy;
  logic rt_busy;

  assign rs_busy = wb_hit(exm_we, exm_addr, bus.in_rs_addr)
                || wb_hit(mwb_we, mwb_addr, bus.in_rs_addr);
  assign rt_busy = wb_hit(exm_we, exm_addr, bus.in_rt_addr)
                || wb_hit(mwb_we, mwb_addr, bus.in_rt_addr);

  // rt is only a real source when the immediate is not selected
  assign interlock = bus.in_valid
                  && (rs_busy || (!bus.in_use_imm && rt_busy));
`endif

  assign bus.in_ready = !rst_n
                     || ((!valid_q || bus.out_ready) && !interlock);
  assign accept  = bus.in_valid && bus.in_ready && !flush;
  assign stalled = valid_q && !bus.out_ready;

  always_comb begin
    ops_d           = ops_q;
    ops_d.a         = fwd_a;
    ops_d.b         = bus.in_use_imm ? bus.in_imm : fwd_b;
    ops_d.alu_op    = bus.in_alu_op;
    ops_d.rd_addr   = bus.in_rd_addr;
    ops_d.reg_write = bus.in_reg_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ops_q     <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        ops_q <= ops_d;
      end
      if (stalled && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_a         = ops_q.a;
  assign bus.out_b         = ops_q.b;
  assign bus.out_alu_op    = ops_q.alu_op;
  assign bus.out_rd_addr   = ops_q.rd_addr;
  assign bus.out_reg_write = ops_q.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed steps plus random traffic
// against a queue-based reference of the stage.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

`ifdef EX_OPERAND_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        exm_we;
  reg_addr_t   exm_addr;
  word_t       exm_data;
  logic        mwb_we;
  reg_addr_t   mwb_addr;
  word_t       mwb_data;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .exm_we    (exm_we),
    .exm_addr  (exm_addr),
    .exm_data  (exm_data),
    .mwb_we    (mwb_we),
    .mwb_addr  (mwb_addr),
    .mwb_data  (mwb_data),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    word_t      a;
    word_t      b;
    logic [2:0] op;
    reg_addr_t  rd;
    logic       we;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic writes(input reg_addr_t src,
                                  input logic we,
                                  input reg_addr_t addr);
    return src != 0 && we && addr == src;
  endfunction

  function automatic word_t ref_operand(input reg_addr_t src,
                                        input word_t rdata);
    if (FWD_EN && writes(src, exm_we, exm_addr)) return exm_data;
    if (FWD_EN && writes(src, mwb_we, mwb_addr)) return mwb_data;
    return rdata;
  endfunction

  function automatic logic busy(input reg_addr_t src);
    return writes(src, exm_we, exm_addr) || writes(src, mwb_we, mwb_addr);
  endfunction

  function automatic logic ref_ready();
    logic haz;
    haz = !FWD_EN && bus.in_valid
       && (busy(bus.in_rs_addr)
           || (!bus.in_use_imm && busy(bus.in_rt_addr)));
    return (q.size() == 0 || bus.out_ready) && !haz;
  endfunction

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_rs_addr   = '0;
    bus.in_rt_addr   = '0;
    bus.in_rs_data   = '0;
    bus.in_rt_data   = '0;
    bus.in_imm       = '0;
    bus.in_use_imm   = 1'b0;
    bus.in_alu_op    = '0;
    bus.in_rd_addr   = '0;
    bus.in_reg_write = 1'b0;
    bus.out_ready    = 1'b1;
    flush    = 1'b0;
    exm_we   = 1'b0;
    exm_addr = '0;
    exm_data = '0;
    mwb_we   = 1'b0;
    mwb_addr = '0;
    mwb_data = '0;
  endtask

  task automatic put(input reg_addr_t rs, input reg_addr_t rt,
                     input word_t rsd, input word_t rtd,
                     input word_t imm, input logic use_imm,
                     input logic [2:0] op, input reg_addr_t rd);
    bus.in_valid     = 1'b1;
    bus.in_rs_addr   = rs;
    bus.in_rt_addr   = rt;
    bus.in_rs_data   = rsd;
    bus.in_rt_data   = rtd;
    bus.in_imm       = imm;
    bus.in_use_imm   = use_imm;
    bus.in_alu_op    = op;
    bus.in_rd_addr   = rd;
    bus.in_reg_write = 1'b1;
  endtask

  // one clock: predict, advance, compare
  task automatic tick();
    logic rdy;
    ent_t e;
    #1;
    rdy = ref_ready();
    check("in_ready", bus.in_ready, rdy);
    e.a  = ref_operand(bus.in_rs_addr, bus.in_rs_data);
    e.b  = bus.in_use_imm ? bus.in_imm
         : ref_operand(bus.in_rt_addr, bus.in_rt_data);
    e.op = bus.in_alu_op;
    e.rd = bus.in_rd_addr;
    e.we = bus.in_reg_write;
    if (q.size() != 0 && !bus.out_ready && cnt < 65535) cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_a", bus.out_a, q[0].a);
      check("out_b", bus.out_b, q[0].b);
      check("out_alu_op", bus.out_alu_op, q[0].op);
      check("out_rd_addr", bus.out_rd_addr, q[0].rd);
      check("out_reg_write", bus.out_reg_write, q[0].we);
    end
    check("stall_cnt", stall_cnt, cnt);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_a"}, bus.out_a, 0);
    check({tag, "_b"}, bus.out_b, 0);
    check({tag, "_op"}, bus.out_alu_op, 0);
    check({tag, "_rd"}, bus.out_rd_addr, 0);
    check({tag, "_we"}, bus.out_reg_write, 0);
    check({tag, "_stall"}, stall_cnt, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check_cleared("reset");
    q.delete();
    cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // r0 is never bypassed
    put(5'd0, 5'd0, 32'h5, 32'h0, 32'h77, 1'b1, ALU_ADD, 5'd1);
    exm_we   = 1'b1;
    exm_addr = 5'd0;
    exm_data = 32'hFF;
    tick();
    check("r0_out_a", bus.out_a, 32'h5);
    check("r0_out_b", bus.out_b, 32'h77);

    // back-pressure holds the entry and counts stall cycles
    idle();
    put(5'd1, 5'd2, 32'hAAAA_0001, 32'h0, 32'h1234, 1'b1,
        ALU_XOR, 5'd9);
    tick();
    check("stall_start", stall_cnt, 16'd0);
    put(5'd4, 5'd5, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, ALU_SUB, 5'd3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_a", bus.out_a, 32'hAAAA_0001);
      check("stall_hold_b", bus.out_b, 32'h1234);
      check("stall_hold_op", bus.out_alu_op, ALU_XOR);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_cnt_step", stall_cnt, i + 1);
    end
    idle();
    tick();
    check("drained", bus.out_valid, 0);

    // flush beats a simultaneous transfer and keeps old operands
    put(5'd6, 5'd6, 32'h6666, 32'h6666, 32'h0, 1'b0, ALU_OR, 5'd6);
    flush = 1'b1;
    tick();
    check("flush_valid", bus.out_valid, 0);
    check("flush_keep_a", bus.out_a, 32'hAAAA_0001);
    check("flush_stall", stall_cnt, 16'd3);
    idle();

`ifdef EX_OPERAND_FORWARD_EN
    put(5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 1'b0, ALU_ADD, 5'd8);
    exm_we = 1'b1; exm_addr = 5'd3; exm_data = 32'h11;
    mwb_we = 1'b1; mwb_addr = 5'd3; mwb_data = 32'h22;
    tick();
    check("fwd_exm_a", bus.out_a, 32'h11);
    check("fwd_rt_plain_b", bus.out_b, 32'h44);
    exm_we   = 1'b0;
    mwb_addr = 5'd4;
    tick();
    check("fwd_rs_plain_a", bus.out_a, 32'h33);
    check("fwd_mwb_b", bus.out_b, 32'h22);
    idle();
    tick();
`else
    put(5'd1, 5'd7, 32'h10, 32'h70, 32'h0, 1'b0, ALU_AND, 5'd2);
    mwb_we = 1'b1; mwb_addr = 5'd7; mwb_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ilk_in_ready", bus.in_ready, 0);
      check("ilk_no_xfer", bus.out_valid, 0);
    end
    mwb_we = 1'b0;
    tick();
    check("ilk_xfer", bus.out_valid, 1);
    check("ilk_out_b", bus.out_b, 32'h70);
    idle();
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      bus.in_valid     = ($urandom_range(0, 9) < 7);
      bus.in_rs_addr   = 5'($urandom_range(0, 7));
      bus.in_rt_addr   = 5'($urandom_range(0, 7));
      bus.in_rs_data   = $urandom;
      bus.in_rt_data   = $urandom;
      bus.in_imm       = $urandom;
      bus.in_use_imm   = 1'($urandom_range(0, 1));
      bus.in_alu_op    = 3'($urandom_range(0, 7));
      bus.in_rd_addr   = 5'($urandom_range(0, 31));
      bus.in_reg_write = 1'($urandom_range(0, 1));
      bus.out_ready    = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 9) == 0);
      exm_we   = ($urandom_range(0, 3) == 0);
      exm_addr = 5'($urandom_range(0, 7));
      exm_data = $urandom;
      mwb_we   = ($urandom_range(0, 3) == 0);
      mwb_addr = 5'($urandom_range(0, 7));
      mwb_data = $urandom;
      tick();
    end

    // asynchronous reset while holding a valid entry
    idle();
    tick();
    put(5'd2, 5'd0, 32'h2222, 32'h0, 32'h5, 1'b1, ALU_RSUB, 5'd4);
    bus.out_ready = 1'b0;
    tick();
    check("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    q.delete();
    cnt = 0;
    #1 rst_n = 1'b1;
    put(5'd2, 5'd0, 32'h4242, 32'h0, 32'h9, 1'b1, ALU_XNOR, 5'd5);
    bus.out_ready = 1'b1;
    tick();
    check("post_reset_a", bus.out_a, 32'h4242);
    check("post_reset_valid", bus.out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
